// File: rtl/io_input_conditioner.sv
// Board input conditioner: per-bit synchroniser, counter debounce, key inversion,
// press pulses and sticky write-1-to-clear press events packed into the core's switch word.
module io_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int N_SW            = 10,
    parameter int N_KEY           = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_SW-1:0]   i_sw,
    input  logic [N_KEY-1:0]  i_key_n,
    input  logic [N_KEY-1:0]  i_evt_clr,
    output logic [N_SW-1:0]   o_sw_db,
    output logic [N_KEY-1:0]  o_key_db,
    output logic [N_KEY-1:0]  o_key_pulse,
    output logic [N_KEY-1:0]  o_key_evt,
    output logic [31:0]       o_io_sw
);

    localparam int N  = N_SW + N_KEY;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // Keys sit in the upper bits and reset to released (raw high), switches to off.
    localparam logic [N-1:0] SYNC_RST = {{N_KEY{1'b1}}, {N_SW{1'b0}}};

    logic [N-1:0]     sync_q [SYNC_STAGES];
    logic [N-1:0]     synced;
    logic [N-1:0]     stable_q;
    logic [CW-1:0]    cnt_q  [N];
    logic [N_KEY-1:0] key_prev_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= SYNC_RST;
        end else begin
            sync_q[0] <= {i_key_n, i_sw};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Keys become active-high only after the chain, so the debouncer sees 1 = pressed.
    assign synced = {~sync_q[SYNC_STAGES-1][N-1:N_SW], sync_q[SYNC_STAGES-1][N_SW-1:0]};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stable_q <= '0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (synced[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_q[i] <= synced[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign o_sw_db  = stable_q[N_SW-1:0];
    assign o_key_db = stable_q[N-1:N_SW];

    // Pulse lands the cycle after the debounced rise; a pending pulse beats a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            key_prev_q  <= '0;
            o_key_pulse <= '0;
            o_key_evt   <= '0;
        end else begin
            key_prev_q  <= o_key_db;
            o_key_pulse <= o_key_db & ~key_prev_q;
            o_key_evt   <= o_key_pulse | (o_key_evt & ~i_evt_clr);
        end
    end

    assign o_io_sw = 32'({o_key_evt, o_key_db, o_sw_db});

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4:
// latency, bounce rejection, pulse/event behaviour, clear collision and reset mid-debounce.
module tb_io_input_conditioner;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int N_SW            = 10;
    localparam int N_KEY           = 4;

    logic              clk;
    logic              rst_n;
    logic [N_SW-1:0]   sw;
    logic [N_KEY-1:0]  key_n;
    logic [N_KEY-1:0]  evt_clr;
    logic [N_SW-1:0]   sw_db;
    logic [N_KEY-1:0]  key_db;
    logic [N_KEY-1:0]  key_pulse;
    logic [N_KEY-1:0]  key_evt;
    logic [31:0]       io_sw;

    int passed = 0;
    int total  = 0;

    io_input_conditioner #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .N_SW(N_SW),
        .N_KEY(N_KEY)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_sw(sw),
        .i_key_n(key_n),
        .i_evt_clr(evt_clr),
        .o_sw_db(sw_db),
        .o_key_db(key_db),
        .o_key_pulse(key_pulse),
        .o_key_evt(key_evt),
        .o_io_sw(io_sw)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst_n   = 1'b0;
        sw      = '0;
        key_n   = '1;
        evt_clr = '0;
        cyc(3);
        chk("reset_io_sw", io_sw, 32'h0);
        chk("reset_pulse", 32'(key_pulse), 32'h0);
        rst_n = 1'b1;
        cyc(3);
        chk("idle_io_sw", io_sw, 32'h0);

        // Switch 0 on: accepted exactly 6 edges after the first sampling edge.
        sw = 10'h001;
        cyc(5);
        chk("sw_latency_early", 32'(sw_db), 32'h0);
        cyc(1);
        chk("sw_latency_exact", 32'(sw_db), 32'h1);
        chk("sw_io_sw", io_sw, 32'h0000_0001);
        sw = 10'h000;
        cyc(8);
        chk("sw_off", io_sw, 32'h0);

        // Key 0 press, pulse, sticky event, release.
        key_n = 4'hE;
        cyc(5);
        chk("key0_early", 32'(key_db), 32'h0);
        cyc(1);
        chk("key0_db", 32'(key_db), 32'h1);
        chk("key0_no_pulse_yet", 32'(key_pulse), 32'h0);
        cyc(1);
        chk("key0_pulse", 32'(key_pulse), 32'h1);
        chk("key0_evt_not_yet", 32'(key_evt), 32'h0);
        cyc(1);
        chk("key0_pulse_gone", 32'(key_pulse), 32'h0);
        chk("key0_held_io", io_sw, 32'h0000_4400);
        key_n = 4'hF;
        cyc(5);
        chk("key0_release_early", io_sw, 32'h0000_4400);
        cyc(1);
        chk("key0_released_io", io_sw, 32'h0000_4000);
        cyc(1);
        chk("key0_release_no_pulse", 32'(key_pulse), 32'h0);

        // Key 1 bounce: low 3, high 2, low 3, then high; never accepted.
        key_n = 4'hD;
        for (int c = 0; c < 14; c++) begin
            if (c == 3) key_n = 4'hF;
            if (c == 5) key_n = 4'hD;
            if (c == 8) key_n = 4'hF;
            cyc(1);
            chk($sformatf("bounce_io_c%0d", c), io_sw, 32'h0000_4000);
            chk($sformatf("bounce_pulse_c%0d", c), 32'(key_pulse), 32'h0);
        end

        // Key 2 with a clear landing in the same cycle as its pulse: set wins.
        key_n = 4'hB;
        cyc(7);
        chk("key2_pulse", 32'(key_pulse), 32'h4);
        evt_clr = 4'h4;
        cyc(1);
        evt_clr = 4'h0;
        chk("collision_evt", 32'(key_evt), 32'h5);
        chk("collision_io", io_sw, 32'h0001_5000);
        cyc(2);
        evt_clr = 4'h4;
        cyc(1);
        evt_clr = 4'h0;
        chk("clear_key2_evt", 32'(key_evt), 32'h1);
        evt_clr = 4'h2;
        cyc(1);
        evt_clr = 4'h0;
        chk("clear_idle_flag", 32'(key_evt), 32'h1);
        key_n = 4'hF;
        cyc(8);
        chk("key2_released", io_sw, 32'h0000_4000);

        // Reset in the middle of a switch 5 debounce discards the count.
        sw = 10'h020;
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk("midreset_io", io_sw, 32'h0);
        cyc(2);
        chk("midreset_sw5", 32'(sw_db), 32'h0);
        rst_n = 1'b1;
        cyc(1);
        chk("after_reset_sw5", 32'(sw_db), 32'h0);
        for (int c = 1; c < 5; c++) begin
            cyc(1);
            chk($sformatf("after_reset_hold_c%0d", c), io_sw, 32'h0);
        end
        cyc(1);
        chk("after_reset_accept", io_sw, 32'h0000_0020);
        chk("after_reset_no_pulse", 32'(key_pulse), 32'h0);

        // All four keys together.
        key_n = 4'h0;
        cyc(6);
        chk("all_keys_db", 32'(key_db), 32'hF);
        chk("all_keys_pre_pulse", 32'(key_pulse), 32'h0);
        cyc(1);
        chk("all_keys_pulse", 32'(key_pulse), 32'hF);
        cyc(1);
        chk("all_keys_pulse_gone", 32'(key_pulse), 32'h0);
        chk("all_keys_io_field", 32'(io_sw[17:10]), 32'hFF);
        chk("all_keys_io", io_sw, 32'h0003_FC20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Input-side companion to the board-level output mapping. Conditions raw DE10-Standard switches and push-buttons into the 32-bit word that feeds the core's i_io_sw port.
- Per-bit synchronisation, counter-based debounce and active-low-to-active-high key conversion.
- Sticky key-press event flags with write-1-to-clear, so software polling the word never misses a short press.
- Sits between the board pins and the pipelined core, in the divided core clock domain.

Parameters:
- SYNC_STAGES, 2, flip-flop stages per input bit before debounce (legal values ≥2).
- DEBOUNCE_CYCLES, 100000, consecutive cycles a synced value must differ from the stable value before it is accepted (10 ms at 10 MHz; legal values ≥1).
- N_SW, 10, number of slide switches.
- N_KEY, 4, number of push-buttons.

Ports:
- i_clk  input  1  core clock (divided clock).
- i_reset  input  1  asynchronous active-low reset.
- i_sw  input  N_SW  raw slide switches, asynchronous to i_clk; 1 = ON.
- i_key_n  input  N_KEY  raw push-buttons, asynchronous to i_clk; active-low (0 = pressed).
- i_evt_clr  input  N_KEY  write-1-to-clear strobes for the sticky event flags; synchronous to i_clk.
- o_sw_db  output  N_SW  debounced switches.
- o_key_db  output  N_KEY  debounced keys, active-high (1 = pressed).
- o_key_pulse  output  N_KEY  one-cycle pulse per debounced press.
- o_key_evt  output  N_KEY  sticky press flags.
- o_io_sw  output  32  word for the core: {(32-N_SW-2*N_KEY)'0, o_key_evt, o_key_db, o_sw_db}. With defaults, bits [9:0] = switches, [13:10] = keys, [17:14] = events, [31:18] = 0.

Behaviour:
- Reset is asynchronous on i_reset low; all state returns to the released/off condition.
  - Switch sync flops = 0; key sync flops = 1 (released).
  - All debounce counters = 0.
  - o_sw_db, o_key_db, o_key_pulse, o_key_evt = 0, so o_io_sw = 32'h0.
  - Reset asserted mid-debounce discards the count. No pulse or event is produced by reset deassertion.
- Synchroniser: every input bit passes through its own SYNC_STAGES-deep flop chain. Keys are inverted after the chain; the debouncer sees active-high.
- Debounce, per bit, independently. Each bit holds a stable register and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Synced == stable: counter <= 0.
  - Synced != stable and counter == DEBOUNCE_CYCLES-1: stable <= synced; counter <= 0.
  - Otherwise: counter <= counter+1.
- Latency: a raw input change held steady updates the debounced output after exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges, counting from the first edge that samples the new value.
- Glitch rejection: if the synced value returns to stable before acceptance, the counter clears and the output does not toggle. The counter never wraps.
- Pulse: o_key_pulse[i] is registered. It is high for exactly one cycle, the cycle after o_key_db[i] goes 0→1. Releases (1→0) produce no pulse. Multiple keys can pulse in the same cycle.
- Event flags: on each edge, o_key_evt[i] <= o_key_pulse[i] | (o_key_evt[i] & ~i_evt_clr[i]).
  - Set and clear in the same cycle: set wins, flag stays 1.
  - Clearing an already-clear flag has no effect.
  - Flags stay set while the key is held or released until cleared.
- Outputs are glitch-free and fully registered. o_io_sw is a pure concatenation of registered outputs.

Test Plan:
- SYNC_STAGES=2, DEBOUNCE_CYCLES=4. Drive i_sw=10'h001 after reset and hold -> o_sw_db becomes 10'h001 exactly 6 edges after the first sampling edge; o_io_sw = 32'h0000_0001.
- i_key_n[0]: 1→0 held -> o_key_db[0]=1 after 6 edges; o_key_pulse[0] high for exactly 1 cycle; o_key_evt[0]=1 and stays 1 after release; o_io_sw = 32'h0000_4400 while held, 32'h0000_4000 after release debounces.
- Bounce: i_key_n[1] low for 3 cycles, high 2, low 3, then high -> o_key_db[1] never rises; no pulse; o_key_evt=0.
- Clear collision: assert i_evt_clr[2]=1 in the same cycle o_key_pulse[2]=1 -> o_key_evt[2]=1. A later single i_evt_clr[2] pulse -> 0 next cycle; other flags unchanged.
- Reset mid-debounce: i_sw[5] toggles, i_reset low after 3 edges, released 2 cycles later with i_sw[5] still 1 -> o_sw_db[5]=0 during and just after reset. It is accepted a full 6 edges after reset release; no spurious key pulse.
- All 4 keys pressed simultaneously -> all four o_key_pulse bits high in the same single cycle; o_io_sw[17:10] = 8'hFF.
